mmm_nlp_acc_90b: RTL and testbench

Column accumulator and digit emitter that sits directly downstream of the 90×90-bit NLP product multiplier in the Montgomery (MMM) datapath. It consumes the multiplier's 181-bit partial products column by column, folds each column into a guarded accumulator, and emits one 90-bit result digit per column. It propagates each column's high part into the next column and flushes the residual carry as trailing digits at frame end. It provides valid/ready backpressure on both sides so that the upstream operand scheduler can stall issue into the multiplier pipe.

---
 rtl/mmm_nlp_acc_90b.sv | 106 ++++++++++
 tb/tb_mmm_nlp_acc_90b.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmm_nlp_acc_90b.sv
// mmm_nlp_acc_90b: column accumulator and digit emitter for the 90x90-bit
// NLP product multiplier. Folds partial products into a guarded accumulator,
// emits one IDW-bit digit per column, then two flush digits per frame.
// Optional feature: define MMM_ACC_OVF_CHK_EN to enable the sticky
// accumulator-overflow flag o_ovf; otherwise o_ovf is tied to 0.
module mmm_nlp_acc_90b #(
  parameter int IDW = 90,
  parameter int PW  = 181,
  parameter int GW  = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_prod_vld,
  output logic           o_prod_rdy,
  input  logic [PW-1:0]  i_prod,
  input  logic           i_col_last,
  input  logic           i_frm_last,
  output logic           o_dig_vld,
  input  logic           i_dig_rdy,
  output logic [IDW-1:0] o_dig,
  output logic           o_dig_last,
  output logic           o_ovf
);

  localparam int ACW = PW + GW;
  // Width of the residual high part left after the frame's last column shift.
  localparam int RW  = ACW - 2 * IDW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]     state;
  logic [ACW-1:0] acc;
  logic [ACW-1:0] sum;
  logic [ACW-1:0] prod_ext;
  logic           flush_sel;   // 0: F0 pending, 1: F1 pending
  logic           dig_free;
  logic           dig_xfer;
  logic           beat_acc;
  logic           col_end;
  logic           f1_done;
  logic           flush_load;

  assign prod_ext   = {{GW{1'b0}}, i_prod};
  assign dig_free   = !o_dig_vld || i_dig_rdy;
  assign dig_xfer   = o_dig_vld && i_dig_rdy;
  assign o_prod_rdy = (state != ST_FLUSH) && dig_free;
  assign beat_acc   = i_prod_vld && o_prod_rdy;
  assign col_end    = beat_acc && i_col_last;
  // F1 is the only digit that carries o_dig_last, so its transfer ends the frame.
  assign f1_done    = (state == ST_FLUSH) && dig_xfer && o_dig_last;
  assign flush_load = (state == ST_FLUSH) && dig_free && !(o_dig_vld && o_dig_last);

`ifdef MMM_ACC_OVF_CHK_EN
  logic carry;
  assign {carry, sum} = {1'b0, acc} + {1'b0, prod_ext};

  // Sticky overflow: any carry out of the accumulator on an accepted beat.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                o_ovf <= 1'b0;
    else if (beat_acc && carry) o_ovf <= 1'b1;
  end
`else
  assign sum   = acc + prod_ext;
  assign o_ovf = 1'b0;
`endif

  // Accumulator and frame state: fold beats, shift at column end, clear after F1.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!i_rstn) begin
      acc   <= '0;
      state <= ST_IDLE;
    end else if (beat_acc) begin
      if (i_col_last) acc <= {{IDW{1'b0}}, sum[ACW-1:IDW]};
      else            acc <= sum;
      state <= (i_col_last && i_frm_last) ? ST_FLUSH : ST_ACCUM;
    end else if (f1_done) begin
      acc   <= '0;
      state <= ST_IDLE;
    end
  end

  // One-entry output register: column digits, then F0 and F1 during flush.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_dig_vld  <= 1'b0;
      o_dig      <= '0;
      o_dig_last <= 1'b0;
      flush_sel  <= 1'b0;
    end else if (col_end) begin
      o_dig_vld  <= 1'b1;
      o_dig      <= sum[IDW-1:0];
      o_dig_last <= 1'b0;
    end else if (flush_load) begin
      o_dig_vld  <= 1'b1;
      o_dig      <= flush_sel ? {{(IDW-RW){1'b0}}, acc[ACW-IDW-1:IDW]} : acc[IDW-1:0];
      o_dig_last <= flush_sel;
      flush_sel  <= ~flush_sel;
    end else if (dig_xfer) begin
      o_dig_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmm_nlp_acc_90b.sv
// Scoreboard bench for mmm_nlp_acc_90b: stimulus pushes hand-computed digits,
// a negedge monitor pops and compares on every digit transfer.
module tb_mmm_nlp_acc_90b;

  localparam int IDW = 90;
  localparam int PW  = 181;
  localparam int ACW = 189;

  logic           i_clk = 1'b0;
  logic           i_rstn;
  logic           i_prod_vld;
  logic           o_prod_rdy;
  logic [PW-1:0]  i_prod;
  logic           i_col_last;
  logic           i_frm_last;
  logic           o_dig_vld;
  logic           i_dig_rdy;
  logic [IDW-1:0] o_dig;
  logic           o_dig_last;
  logic           o_ovf;

  typedef struct {
    logic [IDW-1:0] dig;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mmm_nlp_acc_90b dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_prod_vld (i_prod_vld),
    .o_prod_rdy (o_prod_rdy),
    .i_prod     (i_prod),
    .i_col_last (i_col_last),
    .i_frm_last (i_frm_last),
    .o_dig_vld  (o_dig_vld),
    .i_dig_rdy  (i_dig_rdy),
    .o_dig      (o_dig),
    .o_dig_last (o_dig_last),
    .o_ovf      (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_dig(input logic [IDW-1:0] d, input logic last);
    exp_t e;
    e.dig  = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every digit transfer against the scoreboard head.
  always @(negedge i_clk) begin
    if (i_rstn && o_dig_vld && i_dig_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_digit", {191'b0, o_dig_vld}, 192'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dig", {102'b0, o_dig}, {102'b0, e.dig});
        check("dig_last", {191'b0, o_dig_last}, {191'b0, e.last});
      end
    end
  end

  // Drive one beat and hold it until accepted (bounded).
  task automatic send(input logic [PW-1:0] p, input logic cl, input logic fl);
    int n;
    i_prod_vld = 1'b1;
    i_prod     = p;
    i_col_last = cl;
    i_frm_last = fl;
    n = 0;
    forever begin
      @(negedge i_clk);
      if (o_prod_rdy) break;
      n++;
      if (n > 200) begin
        check("beat_accept_timeout", 192'd1, 192'd0);
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_prod_vld = 1'b0;
    i_col_last = 1'b0;
    i_frm_last = 1'b0;
  endtask

  // Wait for the scoreboard to drain (bounded).
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge i_clk);
      n++;
    end
    check(name, 192'(exp_q.size()), 192'd0);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  logic [PW-1:0]  full;
  logic [PW-1:0]  p90;
  logic [ACW-1:0] model;
  logic [ACW-1:0] shifted;

  initial begin
    full       = '1;
    p90        = '0;
    p90[90]    = 1'b1;
    i_rstn     = 1'b0;
    i_prod_vld = 1'b0;
    i_prod     = '0;
    i_col_last = 1'b0;
    i_frm_last = 1'b0;
    i_dig_rdy  = 1'b1;
    #12;
    check("rst_dig_vld", {191'b0, o_dig_vld}, 192'd0);
    check("rst_dig", {102'b0, o_dig}, 192'd0);
    check("rst_dig_last", {191'b0, o_dig_last}, 192'd0);
    check("rst_ovf", {191'b0, o_ovf}, 192'd0);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
    @(negedge i_clk);
    check("prod_rdy_after_rst", {191'b0, o_prod_rdy}, 192'd1);
    @(posedge i_clk);
    #1;

    // Single beat: 5, then flush digits 0, 0.
    expect_dig(90'd5, 1'b0);
    expect_dig(90'd0, 1'b0);
    expect_dig(90'd0, 1'b1);
    send(181'd5, 1'b1, 1'b1);
    // Digits must come out on consecutive cycles N+1..N+3.
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("single_back_to_back", {191'b0, o_dig_vld}, 192'd1);
      check("flush_blocks_prod", {191'b0, o_prod_rdy}, 192'd0);
    end
    drain("single_drain");

    // Carry propagation: 2^90 + 2^90 -> digit 0 carry 2; + 1 -> 3.
    expect_dig(90'd0, 1'b0);
    expect_dig(90'd3, 1'b0);
    expect_dig(90'd0, 1'b0);
    expect_dig(90'd0, 1'b1);
    send(p90, 1'b0, 1'b0);
    send(p90, 1'b1, 1'b0);
    send(181'd1, 1'b1, 1'b1);
    drain("carry_drain");

    // Full width: (2^181-1) -> 2^90-1, 2^90-1, 1.
    expect_dig({IDW{1'b1}}, 1'b0);
    expect_dig({IDW{1'b1}}, 1'b0);
    expect_dig(90'd1, 1'b1);
    send(full, 1'b1, 1'b1);
    drain("full_drain");

    // frm_last without col_last ignored; zero column still emits a digit.
    expect_dig(90'd9, 1'b0);
    expect_dig(90'd0, 1'b0);
    expect_dig(90'd0, 1'b0);
    expect_dig(90'd0, 1'b1);
    send(181'd4, 1'b0, 1'b1);
    send(181'd5, 1'b1, 1'b0);
    send(181'd0, 1'b1, 1'b1);
    drain("zero_col_drain");

    // Backpressure: hold i_dig_rdy low 5 cycles with a digit pending.
    expect_dig(90'd10, 1'b0);
    expect_dig(90'd20, 1'b0);
    expect_dig(90'd30, 1'b0);
    expect_dig(90'd0, 1'b0);
    expect_dig(90'd0, 1'b1);
    i_dig_rdy = 1'b0;
    send(181'd10, 1'b1, 1'b0);
    fork
      begin
        send(181'd20, 1'b1, 1'b0);
        send(181'd30, 1'b1, 1'b1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge i_clk);
          check("bp_dig_stable", {102'b0, o_dig}, 192'd10);
          check("bp_prod_rdy_low", {191'b0, o_prod_rdy}, 192'd0);
        end
        @(posedge i_clk);
        #1 i_dig_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge i_clk);
          check("bp_no_bubble", {191'b0, o_dig_vld}, 192'd1);
        end
      end
    join
    drain("bp_drain");

    // Reset mid-frame: column 0 digit 1, then 3 beats of column 1, then reset.
    expect_dig(90'd1, 1'b0);
    send(181'd1, 1'b1, 1'b0);
    send(181'd2, 1'b0, 1'b0);
    send(181'd3, 1'b0, 1'b0);
    send(181'd4, 1'b0, 1'b0);
    drain("pre_reset_drain");
    #2 i_rstn = 1'b0;
    #1;
    check("midrst_dig_vld", {191'b0, o_dig_vld}, 192'd0);
    check("midrst_dig", {102'b0, o_dig}, 192'd0);
    check("midrst_dig_last", {191'b0, o_dig_last}, 192'd0);
    check("midrst_ovf", {191'b0, o_ovf}, 192'd0);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;
    expect_dig(90'd7, 1'b0);
    expect_dig(90'd0, 1'b0);
    expect_dig(90'd0, 1'b1);
    send(181'd7, 1'b1, 1'b1);
    drain("post_reset_drain");

`ifdef MMM_ACC_OVF_CHK_EN
    // 256 beats of 2^181-1 fit in 189 bits: no overflow.
    model = '0;
    for (int i = 0; i < 256; i++) model = model + ACW'(full);
    shifted = model >> IDW;
    expect_dig(model[IDW-1:0], 1'b0);
    expect_dig(shifted[IDW-1:0], 1'b0);
    expect_dig({81'b0, shifted[98:90]}, 1'b1);
    for (int i = 0; i < 256; i++) send(full, i == 255, i == 255);
    drain("ovf256_drain");
    check("ovf_256", {191'b0, o_ovf}, 192'd0);
    // 257 beats: carry out on the last accept, value wraps mod 2^189.
    model = '0;
    for (int i = 0; i < 257; i++) model = model + ACW'(full);
    shifted = model >> IDW;
    expect_dig(model[IDW-1:0], 1'b0);
    expect_dig(shifted[IDW-1:0], 1'b0);
    expect_dig({81'b0, shifted[98:90]}, 1'b1);
    for (int i = 0; i < 256; i++) send(full, 1'b0, 1'b0);
    check("ovf_before_257", {191'b0, o_ovf}, 192'd0);
    send(full, 1'b1, 1'b1);
    check("ovf_after_257", {191'b0, o_ovf}, 192'd1);
    drain("ovf257_drain");
    check("ovf_sticky", {191'b0, o_ovf}, 192'd1);
`else
    check("ovf_tied_low", {191'b0, o_ovf}, 192'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
